// File: rtl/fft_band_equalizer.sv
// Per-band complex gain stage between forward and inverse FFT streams.
// Two-stage pipeline; gains latch on frame start, framing faults are flagged sticky.
module fft_band_equalizer #(
    parameter int unsigned SAMPLES      = 4096,
    parameter int unsigned LOG2_SAMPLES = 12,
    parameter int unsigned BANDS        = 16,
    parameter int unsigned LOG2_BANDS   = 4,
    parameter logic [7:0]  UNITY        = 8'd64
) (
    input  logic                  fft_clk,
    input  logic                  reset_n,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic                  sink_sop,
    input  logic                  sink_eop,
    input  logic [15:0]           sink_real,
    input  logic [15:0]           sink_imag,
    input  logic [5:0]            sink_exp,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic                  source_sop,
    output logic                  source_eop,
    output logic [15:0]           source_real,
    output logic [15:0]           source_imag,
    output logic [5:0]            source_exp,
    input  logic                  gain_we,
    input  logic [LOG2_BANDS-1:0] gain_addr,
    input  logic [7:0]            gain_data,
    input  logic                  bypass,
    output logic                  frame_err,
    input  logic                  clr_err
);

    localparam int unsigned SHIFT = LOG2_SAMPLES - 1 - LOG2_BANDS;

    typedef logic [LOG2_SAMPLES-1:0] bin_t;
    typedef logic [LOG2_SAMPLES:0]   wide_t;

    localparam bin_t  LAST_BIN = bin_t'(SAMPLES - 1);
    localparam bin_t  ONE_BIN  = bin_t'(1);
    localparam wide_t HALF_W   = wide_t'(SAMPLES / 2);
    localparam wide_t FULL_W   = wide_t'(SAMPLES);
    localparam wide_t BANDS_W  = wide_t'(BANDS);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // Mirror bins k and SAMPLES-k onto the same band; Nyquist lands past the top band.
    function automatic logic [LOG2_BANDS-1:0] band_of(input bin_t k);
        wide_t kx, m, b;
        kx = {1'b0, k};
        m  = (kx < HALF_W) ? kx : FULL_W - kx;
        b  = m >> SHIFT;
        if (b >= BANDS_W) begin
            band_of = LOG2_BANDS'(BANDS - 1);
        end else begin
            band_of = b[LOG2_BANDS-1:0];
        end
    endfunction

    function automatic logic [15:0] scale(input logic signed [15:0] x, input logic [7:0] g);
        logic signed [24:0] p;
        logic signed [18:0] r;
        p = 25'(x) * 25'($signed({1'b0, g}));
        r = p[24:6];
        if (r > 19'sd32767) begin
            scale = 16'h7fff;
        end else if (r < -19'sd32768) begin
            scale = 16'h8000;
        end else begin
            scale = r[15:0];
        end
    endfunction

    state_e                  state_q, state_d;
    bin_t                    k_q, k_d, idx;
    logic                    en, acc, fwd, out_eop, err_set;
    logic [7:0]              pend_q [BANDS];
    logic [7:0]              pend_d [BANDS];
    logic [7:0]              act_q  [BANDS];
    logic                    bypass_q;
    logic [LOG2_BANDS-1:0]   band_sel;
    logic [7:0]              gain_sel;

    logic                    s1_valid, s1_sop, s1_eop;
    logic [15:0]             s1_real, s1_imag;
    logic [7:0]              s1_gain;
    logic [5:0]              s1_exp;

    assign en         = !source_valid || source_ready;
    assign sink_ready = en;
    assign acc        = sink_valid && en;

    always_comb begin
        pend_d = pend_q;
        if (gain_we) begin
            pend_d[gain_addr] = gain_data;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        err_set = 1'b0;
        fwd     = 1'b0;
        out_eop = sink_eop;
        idx     = sink_sop ? '0 : k_q;
        if (acc) begin
            if (state_q == StIdle && !sink_sop) begin
                err_set = 1'b1;
            end else begin
                fwd = 1'b1;
                if (state_q == StRun && sink_sop) begin
                    err_set = 1'b1;
                end
                if (sink_eop) begin
                    state_d = StIdle;
                    k_d     = '0;
                    if (idx != LAST_BIN) begin
                        err_set = 1'b1;
                    end
                end else if (idx == LAST_BIN) begin
                    // Frame overran without eop: close it ourselves.
                    out_eop = 1'b1;
                    err_set = 1'b1;
                    state_d = StIdle;
                    k_d     = '0;
                end else begin
                    state_d = StRun;
                    k_d     = idx + ONE_BIN;
                end
            end
        end
    end

    // The sop beat sees the freshly copied table, including a same-cycle write.
    always_comb begin
        band_sel = band_of(idx);
        if (sink_sop) begin
            gain_sel = bypass ? UNITY : pend_d[band_sel];
        end else begin
            gain_sel = bypass_q ? UNITY : act_q[band_sel];
        end
    end

    always_ff @(posedge fft_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            k_q          <= '0;
            bypass_q     <= 1'b0;
            frame_err    <= 1'b0;
            for (int i = 0; i < BANDS; i++) begin
                pend_q[i] <= UNITY;
                act_q[i]  <= UNITY;
            end
            s1_valid     <= 1'b0;
            s1_sop       <= 1'b0;
            s1_eop       <= 1'b0;
            s1_real      <= '0;
            s1_imag      <= '0;
            s1_gain      <= '0;
            s1_exp       <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_real  <= '0;
            source_imag  <= '0;
            source_exp   <= '0;
        end else begin
            pend_q  <= pend_d;
            state_q <= state_d;
            k_q     <= k_d;
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (acc && sink_sop) begin
                act_q    <= pend_d;
                bypass_q <= bypass;
                s1_exp   <= sink_exp;
            end
            if (en) begin
                s1_valid     <= fwd;
                s1_sop       <= fwd && sink_sop;
                s1_eop       <= fwd && out_eop;
                s1_real      <= sink_real;
                s1_imag      <= sink_imag;
                s1_gain      <= gain_sel;
                source_valid <= s1_valid;
                source_sop   <= s1_valid && s1_sop;
                source_eop   <= s1_valid && s1_eop;
                source_real  <= scale(s1_real, s1_gain);
                source_imag  <= scale(s1_imag, s1_gain);
                if (s1_valid && s1_sop) begin
                    source_exp <= s1_exp;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_band_equalizer.sv
// Randomized bench for fft_band_equalizer against a frame-level behavioural model.
module tb_fft_band_equalizer;

    localparam int N  = 4096;
    localparam int NB = 16;

    logic        fft_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sink_valid = 1'b0, sink_ready, sink_sop = 1'b0, sink_eop = 1'b0;
    logic [15:0] sink_real = '0, sink_imag = '0;
    logic [5:0]  sink_exp = '0;
    logic        source_valid, source_ready = 1'b1, source_sop, source_eop;
    logic [15:0] source_real, source_imag;
    logic [5:0]  source_exp;
    logic        gain_we = 1'b0;
    logic [3:0]  gain_addr = '0;
    logic [7:0]  gain_data = '0;
    logic        bypass = 1'b0, frame_err, clr_err = 1'b0;

    fft_band_equalizer dut (
        .fft_clk     (fft_clk),
        .reset_n     (reset_n),
        .sink_valid  (sink_valid),
        .sink_ready  (sink_ready),
        .sink_sop    (sink_sop),
        .sink_eop    (sink_eop),
        .sink_real   (sink_real),
        .sink_imag   (sink_imag),
        .sink_exp    (sink_exp),
        .source_valid(source_valid),
        .source_ready(source_ready),
        .source_sop  (source_sop),
        .source_eop  (source_eop),
        .source_real (source_real),
        .source_imag (source_imag),
        .source_exp  (source_exp),
        .gain_we     (gain_we),
        .gain_addr   (gain_addr),
        .gain_data   (gain_data),
        .bypass      (bypass),
        .frame_err   (frame_err),
        .clr_err     (clr_err)
    );

    initial forever #5 fft_clk = ~fft_clk;

    typedef struct {
        bit sop;
        bit eop;
        int re;
        int im;
        int ex;
        int cyc;
    } beat_t;

    beat_t expq[$];
    int    total = 0, bad = 0, cyc = 0;
    bit    lat_chk = 1'b1;
    int    rmode = 0;
    int    m_pend[NB], m_act[NB];
    bit    m_byp, m_in, m_err;
    int    m_cnt, m_exp;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic int band_of(input int k);
        int m, b;
        m = (k < N / 2) ? k : N - k;
        b = m / (N / 2 / NB);
        return (b > NB - 1) ? NB - 1 : b;
    endfunction

    // Gain is x * g / 64 rounded toward minus infinity, then clipped to 16 bits.
    function automatic int scale(input int x, input int g);
        int p, q;
        p = x * g;
        q = p / 64;
        if (p < 0 && (p % 64) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_pend[i] = 64;
            m_act[i]  = 64;
        end
        m_in  = 0;
        m_err = 0;
        m_cnt = 0;
        m_exp = 0;
        m_byp = 0;
        expq.delete();
    endtask

    always @(negedge fft_clk) begin
        beat_t e;
        bit    set, last, oe;
        int    k, g;
        cyc++;
        if (!reset_n) begin
            model_reset();
        end else begin
            check("sink_ready", sink_ready, int'(!source_valid || source_ready));
            check("frame_err", frame_err, m_err);
            if (source_valid && source_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("out_sop", source_sop, e.sop);
                    check("out_eop", source_eop, e.eop);
                    check("out_real", int'($signed(source_real)), e.re);
                    check("out_imag", int'($signed(source_imag)), e.im);
                    check("out_exp", source_exp, e.ex);
                    if (lat_chk) check("latency", cyc - e.cyc, 2);
                end
            end
            if (gain_we) m_pend[gain_addr] = gain_data;
            set = 0;
            if (sink_valid && sink_ready) begin
                if (sink_sop) begin
                    if (m_in) set = 1;
                    m_act = m_pend;
                    m_byp = bypass;
                    m_exp = sink_exp;
                    m_cnt = 0;
                    m_in  = 1;
                end
                if (m_in) begin
                    k    = m_cnt;
                    last = (k == N - 1);
                    oe   = sink_eop || last;
                    if (sink_eop != last) set = 1;
                    g     = m_byp ? 64 : m_act[band_of(k)];
                    e.sop = sink_sop;
                    e.eop = oe;
                    e.re  = scale(int'($signed(sink_real)), g);
                    e.im  = scale(int'($signed(sink_imag)), g);
                    e.ex  = m_exp;
                    e.cyc = cyc;
                    expq.push_back(e);
                    if (oe) m_in = 0;
                    else m_cnt++;
                end else begin
                    set = 1;
                end
            end
            if (set) m_err = 1;
            else if (clr_err) m_err = 0;
        end
    end

    initial begin
        int ph = 0;
        logic [3:0] pat = 4'b1001;
        forever begin
            @(posedge fft_clk);
            #1;
            case (rmode)
                0: source_ready = 1'b1;
                1: begin
                    source_ready = pat[ph];
                    ph = (ph + 1) % 4;
                end
                default: source_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_beat(input bit sop, input bit eop, input int re, input int im,
                             input int ex);
        int n = 0;
        bit acc;
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_real  = 16'(re);
        sink_imag  = 16'(im);
        sink_exp   = 6'(ex);
        do begin
            @(negedge fft_clk);
            acc = sink_ready;
            @(posedge fft_clk);
            #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int dmode, input int nbeats, input bit do_eop,
                              input bit gaps, input bit byp, input int wr_k,
                              input int wr_band, input int wr_val);
        int re, im, ex;
        ex = $urandom_range(0, 63);
        bypass = byp;
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && $urandom_range(0, 7) == 0) begin
                sink_valid = 1'b0;
                @(posedge fft_clk);
                #1;
            end
            case (dmode)
                0: begin re = k; im = -k; end
                1: begin re = 1000; im = 1000; end
                2: begin
                    if (k >= 384 && k < 512) begin
                        re = 32767;
                        im = -32768;
                    end else begin
                        re = int'($urandom_range(0, 65535)) - 32768;
                        im = int'($urandom_range(0, 65535)) - 32768;
                    end
                end
                default: begin
                    re = int'($urandom_range(0, 65535)) - 32768;
                    im = int'($urandom_range(0, 65535)) - 32768;
                end
            endcase
            if (k == wr_k) begin
                gain_we   = 1'b1;
                gain_addr = 4'(wr_band);
                gain_data = 8'(wr_val);
            end
            send_beat(k == 0, do_eop && k == nbeats - 1, re, im,
                      (k == 0) ? ex : int'($urandom_range(0, 63)));
            gain_we = 1'b0;
        end
        sink_valid = 1'b0;
        bypass     = 1'b0;
    endtask

    task automatic write_gain(input int b, input int v);
        sink_valid = 1'b0;
        gain_we    = 1'b1;
        gain_addr  = 4'(b);
        gain_data  = 8'(v);
        @(posedge fft_clk);
        #1;
        gain_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 20000) begin
            @(posedge fft_clk);
            #1;
            n++;
        end
        check("drain", expq.size(), 0);
        repeat (3) @(posedge fft_clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge fft_clk);
        #1;
        clr_err = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge fft_clk);
        #1;
        check("rst_source_valid", source_valid, 0);
        check("rst_source_sop", source_sop, 0);
        check("rst_source_eop", source_eop, 0);
        check("rst_source_real", source_real, 0);
        check("rst_source_imag", source_imag, 0);
        check("rst_source_exp", source_exp, 0);
        check("rst_frame_err", frame_err, 0);
        reset_n = 1'b1;
        @(posedge fft_clk);
        #1;
        check("rst_sink_ready", sink_ready, 1);

        // Unity ramp with exact latency.
        send_frame(0, N, 1, 0, 0, -1, 0, 0);
        drain();
        check("ramp_no_err", frame_err, 0);

        // Band 0 doubled, everything else muted.
        write_gain(0, 128);
        for (int b = 1; b < NB; b++) write_gain(b, 0);
        send_frame(1, N, 1, 0, 0, -1, 0, 0);
        drain();

        // Saturation in band 3 under random backpressure and input gaps.
        rmode   = 2;
        lat_chk = 0;
        for (int b = 0; b < NB; b++) write_gain(b, $urandom_range(0, 255));
        write_gain(3, 255);
        send_frame(2, N, 1, 1, 0, -1, 0, 0);
        drain();

        // Mid-frame write must wait for the next sop.
        rmode   = 0;
        lat_chk = 1;
        for (int b = 0; b < NB; b++) write_gain(b, 64);
        send_frame(3, N, 1, 0, 0, 1000, 0, 0);
        send_frame(0, N, 1, 0, 0, -1, 0, 0);
        drain();

        // 1-0-0-1 backpressure; a write coinciding with sop applies to that frame.
        rmode   = 1;
        lat_chk = 0;
        for (int b = 0; b < NB; b++) write_gain(b, $urandom_range(0, 255));
        send_frame(3, N, 1, 0, 0, 0, 0, $urandom_range(0, 255));
        drain();

        // Bypass overrides the table for the whole frame.
        rmode = 2;
        send_frame(3, N, 1, 1, 1, -1, 0, 0);
        drain();

        // Early eop, then a stray beat while idle.
        rmode   = 0;
        lat_chk = 1;
        send_frame(3, 101, 1, 0, 0, -1, 0, 0);
        drain();
        check("early_eop_err", frame_err, 1);
        send_beat(0, 0, 5, 5, 0);
        sink_valid = 1'b0;
        drain();
        check("stray_err", frame_err, 1);
        pulse_clr();
        check("err_cleared", frame_err, 0);

        // sop in mid-frame restarts the frame.
        send_frame(3, 200, 0, 0, 0, -1, 0, 0);
        send_frame(3, N, 1, 0, 0, -1, 0, 0);
        drain();
        check("restart_err", frame_err, 1);
        pulse_clr();

        // Missing eop gets closed at the last bin.
        send_frame(3, N, 0, 0, 0, -1, 0, 0);
        drain();
        check("overrun_err", frame_err, 1);
        pulse_clr();

        // Asynchronous reset mid-frame, then a clean frame.
        send_frame(3, 500, 0, 0, 0, -1, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", source_valid, 0);
        check("midrst_err", frame_err, 0);
        repeat (2) @(posedge fft_clk);
        #1;
        reset_n = 1'b1;
        send_frame(0, N, 1, 0, 0, -1, 0, 0);
        drain();
        check("post_reset_err", frame_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
